// File: rtl/card_pkg.sv
// Shared types and constants for the card overlay.
//   card_symbol_t : suit encoding written into the slot table
//   card_slot_t   : one on-screen card slot (position, face, visibility)
//   vga_timing_t  : timing signals carried alongside each pixel
//   card_id_f     : maps suit/number onto the card ROM index
package card_pkg;

  typedef enum logic [1:0] {
    SYM_SERCE = 2'd0,
    SYM_PIK   = 2'd1,
    SYM_ROMB  = 2'd2,
    SYM_TREFL = 2'd3
  } card_symbol_t;

  localparam int          CARD_W    = 64;
  localparam int          CARD_H    = 96;
  localparam logic [11:0] KEY_COLOR = 12'hF0F;

  typedef struct packed {
    logic [10:0]  x;
    logic [10:0]  y;
    card_symbol_t symbol;
    logic [3:0]   number;
    logic         show;
  } card_slot_t;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } vga_timing_t;

  // ROMs are ordered suit-major, 13 faces per suit; number is 1-based.
  function automatic logic [5:0] card_id_f(card_symbol_t sym, logic [3:0] num);
    card_id_f = ({4'd0, sym} * 6'd13) + {2'd0, num} - 6'd1;
  endfunction

endpackage

// File: rtl/card_hit_detect.sv
// Combinational slot hit test with priority select.
//   hcount_i/vcount_i : current pixel
//   slots_i           : slot table
//   hit_o             : some visible slot covers the pixel
//   sel_o             : highest-index covering slot (valid when hit_o)
module card_hit_detect
  import card_pkg::*;
#(
  parameter int SLOTS  = 8,
  parameter int CARD_W = 64,
  parameter int CARD_H = 96
) (
  input  logic [10:0]              hcount_i,
  input  logic [10:0]              vcount_i,
  input  card_slot_t               slots_i [SLOTS],
  output logic                     hit_o,
  output logic [$clog2(SLOTS)-1:0] sel_o
);

  localparam int IDX_W = $clog2(SLOTS);

  // 12-bit compares so a card straddling x=2047 does not wrap back to 0.
  // Ascending scan: a later hit overwrites, so the highest index wins.
  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (slots_i[i].show &&
          ({1'b0, hcount_i} >= {1'b0, slots_i[i].x}) &&
          ({1'b0, hcount_i} <  ({1'b0, slots_i[i].x} + 12'(CARD_W))) &&
          ({1'b0, vcount_i} >= {1'b0, slots_i[i].y}) &&
          ({1'b0, vcount_i} <  ({1'b0, slots_i[i].y} + 12'(CARD_H)))) begin
        hit_o = 1'b1;
        sel_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/card_draw_sched.sv
// Card overlay: slot table, clear sequencer and 2-stage draw pipeline.
//   clk, rst                  : clock, async active-high reset
//   hcount/vcount/sync/blnk   : VGA timing in, delayed 2 cycles out
//   rgb_in / rgb_out          : background pixel in, composed pixel out
//   slot_wr_*                 : slot-table write (valid/ready, vblank only)
//   clear_req / clear_done    : blank all slots, one-cycle completion pulse
//   rom_addr, card_id         : registered ROM address and ROM select
//   rom_data                  : ROM output, one cycle after rom_addr
//
// state  | meaning
// IDLE   | table writable during vblank, waiting for clear_req
// CLEAR  | zeroing show of one slot per cycle, index clr_idx_q
module card_draw_sched
  import card_pkg::*;
#(
  parameter int                    SLOTS      = 8,
  parameter int                    CARD_W     = card_pkg::CARD_W,
  parameter int                    CARD_H     = card_pkg::CARD_H,
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] KEY_COLOR  = 12'hF0F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [10:0]              hcount_in,
  input  logic [10:0]              vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  input  logic [11:0]              rgb_in,
  input  logic                     slot_wr_valid,
  output logic                     slot_wr_ready,
  input  logic [$clog2(SLOTS)-1:0] slot_wr_idx,
  input  logic [10:0]              slot_wr_x,
  input  logic [10:0]              slot_wr_y,
  input  logic [1:0]               slot_wr_symbol,
  input  logic [3:0]               slot_wr_number,
  input  logic                     slot_wr_show,
  input  logic                     clear_req,
  output logic                     clear_done,
  output logic [ADDR_WIDTH-1:0]    rom_addr,
  output logic [5:0]               card_id,
  input  logic [DATA_WIDTH-1:0]    rom_data,
  output logic [10:0]              hcount_out,
  output logic [10:0]              vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [11:0]              rgb_out
);

  localparam int IDX_W = $clog2(SLOTS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
  logic             clear_done_q, clear_done_d;
  card_slot_t       slot_q [SLOTS];
  card_slot_t       wr_slot;
  logic             wr_fire;
  logic             clr_last;

  // Holding ready low while clear_req is up makes a same-cycle clear win
  // without ever completing a handshake that is then dropped.
  assign slot_wr_ready = !rst && (state_q == ST_IDLE) && vblnk_in && !clear_req;
  assign wr_fire       = slot_wr_valid && slot_wr_ready;
  assign clr_last      = (clr_idx_q == IDX_W'(SLOTS - 1));
  assign clear_done    = clear_done_q;

  always_comb begin
    wr_slot.x      = slot_wr_x;
    wr_slot.y      = slot_wr_y;
    wr_slot.symbol = card_symbol_t'(slot_wr_symbol);
    wr_slot.number = slot_wr_number;
    wr_slot.show   = slot_wr_show && (slot_wr_number != 4'd0) && (slot_wr_number <= 4'd13);
  end

  always_comb begin
    state_d      = state_q;
    clr_idx_d    = clr_idx_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      default: begin
        if (clr_last) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b1;
        end else begin
          clr_idx_d = clr_idx_q + IDX_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clr_idx_q    <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      clear_done_q <= clear_done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      slot_q[clr_idx_q].show <= 1'b0;
    end else if (wr_fire) begin
      slot_q[slot_wr_idx] <= wr_slot;
    end
  end

  // Stage 1: hit test against the table as it stands this cycle; the
  // registered results travel with the pixel, so later table writes cannot
  // reach pixels already in flight.
  logic             hit_s0;
  logic [IDX_W-1:0] sel_s0;
  card_slot_t       win_slot;
  logic [10:0]      dx_s0, dy_s0;

  card_hit_detect #(
    .SLOTS  (SLOTS),
    .CARD_W (CARD_W),
    .CARD_H (CARD_H)
  ) u_hit (
    .hcount_i (hcount_in),
    .vcount_i (vcount_in),
    .slots_i  (slot_q),
    .hit_o    (hit_s0),
    .sel_o    (sel_s0)
  );

  assign win_slot = slot_q[sel_s0];
  assign dx_s0    = hcount_in - win_slot.x;
  assign dy_s0    = vcount_in - win_slot.y;

  vga_timing_t     tim_s0, tim_s1, tim_s2;
  logic            hit_s1, hit_s2;
  logic [11:0]     rgb_s1, rgb_s2;

  assign tim_s0 = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr <= '0;
      card_id  <= '0;
      hit_s1   <= 1'b0;
      tim_s1   <= '0;
      rgb_s1   <= '0;
      hit_s2   <= 1'b0;
      tim_s2   <= '0;
      rgb_s2   <= '0;
    end else begin
      if (hit_s0) begin
        rom_addr <= ADDR_WIDTH'(dy_s0) * ADDR_WIDTH'(CARD_W) + ADDR_WIDTH'(dx_s0);
        card_id  <= card_id_f(win_slot.symbol, win_slot.number);
      end
      hit_s1 <= hit_s0;
      tim_s1 <= tim_s0;
      rgb_s1 <= rgb_in;
      hit_s2 <= hit_s1;
      tim_s2 <= tim_s1;
      rgb_s2 <= rgb_s1;
    end
  end

  // Stage 2: the ROM registers rom_addr itself, so rom_data lines up with the
  // stage-2 registers and the final mux is combinational off them.
  assign hcount_out = tim_s2.hcount;
  assign vcount_out = tim_s2.vcount;
  assign hsync_out  = tim_s2.hsync;
  assign vsync_out  = tim_s2.vsync;
  assign hblnk_out  = tim_s2.hblnk;
  assign vblnk_out  = tim_s2.vblnk;

  always_comb begin
    rgb_out = rgb_s2;
    if (tim_s2.hblnk || tim_s2.vblnk) begin
      rgb_out = '0;
    end else if (hit_s2 && (rom_data != KEY_COLOR)) begin
      rgb_out = 12'(rom_data);
    end
  end

endmodule

// File: tb/tb_card_draw_sched.sv
module tb_card_draw_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        slot_wr_valid, slot_wr_ready;
  logic [2:0]  slot_wr_idx;
  logic [10:0] slot_wr_x, slot_wr_y;
  logic [1:0]  slot_wr_symbol;
  logic [3:0]  slot_wr_number;
  logic        slot_wr_show;
  logic        clear_req, clear_done;
  logic [12:0] rom_addr;
  logic [5:0]  card_id;
  logic [11:0] rom_data = 12'h000;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  logic [1:0]  rom_mode = 2'd0;
  logic [12:0] last_addr = 13'd0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  card_draw_sched dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .slot_wr_valid(slot_wr_valid), .slot_wr_ready(slot_wr_ready),
    .slot_wr_idx(slot_wr_idx), .slot_wr_x(slot_wr_x), .slot_wr_y(slot_wr_y),
    .slot_wr_symbol(slot_wr_symbol), .slot_wr_number(slot_wr_number), .slot_wr_show(slot_wr_show),
    .clear_req(clear_req), .clear_done(clear_done),
    .rom_addr(rom_addr), .card_id(card_id), .rom_data(rom_data),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Registered card ROM model: pattern encodes card_id and low address bits.
  always @(posedge clk) begin
    case (rom_mode)
      2'd0:    rom_data <= {card_id, rom_addr[5:0]};
      2'd1:    rom_data <= 12'hF0F;
      default: rom_data <= 12'h0F0;
    endcase
  end

  typedef struct {
    logic [10:0] hc;
    logic [10:0] vc;
    logic [11:0] rgb;
    logic        hb;
    logic [1:0]  mode;
    logic        hit;
    logic [12:0] addr;
    logic [5:0]  id;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input logic [10:0] hc, input logic [10:0] vc, input logic [11:0] rgb,
                         input logic hb, input logic vb);
    hcount_in = hc; vcount_in = vc; rgb_in = rgb; hblnk_in = hb; vblnk_in = vb;
    hsync_in = hc[0]; vsync_in = vc[0];
  endtask

  task automatic write_slot(input logic [2:0] idx, input logic [10:0] x, input logic [10:0] y,
                            input logic [1:0] sym, input logic [3:0] num);
    set_pix(11'd5, 11'd1023, 12'h000, 1'b0, 1'b1);
    slot_wr_valid = 1'b1; slot_wr_idx = idx; slot_wr_x = x; slot_wr_y = y;
    slot_wr_symbol = sym; slot_wr_number = num; slot_wr_show = 1'b1;
    #1;
    chk("wr_ready", slot_wr_ready, 1);
    tick();
    slot_wr_valid = 1'b0;
    vblnk_in = 1'b0;
  endtask

  // Drive one pixel, check stage 1, then push a filler pixel so stage 2 must
  // show exactly the 2-cycle-delayed vector and not the filler.
  task automatic run_vec(input vec_t v, input string nm);
    set_pix(v.hc, v.vc, v.rgb, v.hb, 1'b0);
    rom_mode = v.mode;
    tick();
    if (v.hit) begin
      chk({nm, " rom_addr"}, rom_addr, v.addr);
      chk({nm, " card_id"}, card_id, v.id);
      last_addr = v.addr;
    end else begin
      chk({nm, " rom_addr_hold"}, rom_addr, last_addr);
    end
    set_pix(11'd5, 11'd1023, 12'h000, 1'b0, 1'b0);
    hsync_in = ~v.hc[0];
    tick();
    chk({nm, " rgb_out"}, rgb_out, v.exp_rgb);
    chk({nm, " hcount_out"}, hcount_out, v.hc);
    chk({nm, " vcount_out"}, vcount_out, v.vc);
    chk({nm, " hsync_out"}, hsync_out, v.hc[0]);
    chk({nm, " hblnk_out"}, hblnk_out, v.hb);
  endtask

  initial begin
    int seen_done;
    vecs[0]  = '{11'd100,  11'd200, 12'h123, 1'b0, 2'd0, 1'b1, 13'd0,    6'd17, 12'h440};
    vecs[1]  = '{11'd163,  11'd295, 12'h234, 1'b0, 2'd0, 1'b1, 13'd6143, 6'd17, 12'h47F};
    vecs[2]  = '{11'd164,  11'd200, 12'h345, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h345};
    vecs[3]  = '{11'd100,  11'd296, 12'h456, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h456};
    vecs[4]  = '{11'd99,   11'd200, 12'h567, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h567};
    vecs[5]  = '{11'd300,  11'd300, 12'h678, 1'b0, 2'd0, 1'b1, 13'd0,    6'd51, 12'hCC0};
    vecs[6]  = '{11'd299,  11'd300, 12'h789, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h789};
    vecs[7]  = '{11'd120,  11'd210, 12'h89A, 1'b0, 2'd1, 1'b1, 13'd660,  6'd17, 12'h89A};
    vecs[8]  = '{11'd120,  11'd210, 12'h89A, 1'b0, 2'd2, 1'b1, 13'd660,  6'd17, 12'h0F0};
    vecs[9]  = '{11'd120,  11'd210, 12'h89A, 1'b1, 2'd0, 1'b1, 13'd660,  6'd17, 12'h000};
    vecs[10] = '{11'd2040, 11'd10,  12'h111, 1'b0, 2'd0, 1'b1, 13'd0,    6'd26, 12'h680};
    vecs[11] = '{11'd2047, 11'd10,  12'h222, 1'b0, 2'd0, 1'b1, 13'd7,    6'd26, 12'h687};
    vecs[12] = '{11'd0,    11'd10,  12'h333, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h333};
    vecs[13] = '{11'd55,   11'd10,  12'h444, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h444};
    vecs[14] = '{11'd500,  11'd500, 12'h555, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h555};
    vecs[15] = '{11'd510,  11'd500, 12'h666, 1'b0, 2'd0, 1'b0, 13'd0,    6'd0,  12'h666};

    rst = 1'b1;
    slot_wr_valid = 1'b0; slot_wr_idx = '0; slot_wr_x = '0; slot_wr_y = '0;
    slot_wr_symbol = '0; slot_wr_number = '0; slot_wr_show = 1'b0; clear_req = 1'b0;
    set_pix(11'd7, 11'd9, 12'hFFF, 1'b0, 1'b1);
    tick();
    tick();
    chk("rst wr_ready", slot_wr_ready, 0);
    chk("rst clear_done", clear_done, 0);
    chk("rst rom_addr", rom_addr, 0);
    chk("rst card_id", card_id, 0);
    chk("rst rgb_out", rgb_out, 0);
    chk("rst hcount_out", hcount_out, 0);
    chk("rst hsync_out", hsync_out, 0);
    rst = 1'b0;
    #1;

    write_slot(3'd0, 11'd100,  11'd200, 2'd1, 4'd5);
    write_slot(3'd1, 11'd300,  11'd300, 2'd0, 4'd2);
    write_slot(3'd3, 11'd300,  11'd300, 2'd3, 4'd13);
    write_slot(3'd2, 11'd2040, 11'd10,  2'd2, 4'd1);
    write_slot(3'd4, 11'd500,  11'd500, 2'd0, 4'd0);
    write_slot(3'd7, 11'd505,  11'd500, 2'd2, 4'd14);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Write held outside vblank must stall, then go through on first vblank cycle.
    slot_wr_valid = 1'b1; slot_wr_idx = 3'd5; slot_wr_x = 11'd600; slot_wr_y = 11'd600;
    slot_wr_symbol = 2'd1; slot_wr_number = 4'd1; slot_wr_show = 1'b1;
    set_pix(11'd5, 11'd1023, 12'h000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall wr_ready", slot_wr_ready, 0);
      tick();
    end
    slot_wr_valid = 1'b0;
    run_vec('{11'd600, 11'd600, 12'h9AB, 1'b0, 2'd0, 1'b0, 13'd0, 6'd0, 12'h9AB}, "stalled");
    slot_wr_valid = 1'b1;
    vblnk_in = 1'b1;
    #1;
    chk("vblank wr_ready", slot_wr_ready, 1);
    tick();
    slot_wr_valid = 1'b0;
    vblnk_in = 1'b0;
    run_vec('{11'd600, 11'd600, 12'h9AB, 1'b0, 2'd0, 1'b1, 13'd0, 6'd13, 12'h340}, "accepted");

    // Clear races a write; clear wins, done 9 cycles on, mid-clear request ignored.
    set_pix(11'd5, 11'd1023, 12'h000, 1'b0, 1'b1);
    clear_req = 1'b1;
    slot_wr_valid = 1'b1; slot_wr_idx = 3'd6; slot_wr_x = 11'd700; slot_wr_y = 11'd700;
    slot_wr_symbol = 2'd0; slot_wr_number = 4'd3; slot_wr_show = 1'b1;
    #1;
    chk("clear race wr_ready", slot_wr_ready, 0);
    tick();
    clear_req = 1'b0;
    slot_wr_valid = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      chk($sformatf("clear_done c%0d", k), clear_done, (k == 9) ? 1 : 0);
      if (k <= 8) chk($sformatf("clear wr_ready c%0d", k), slot_wr_ready, 0);
      clear_req = (k == 3);
      tick();
    end
    clear_req = 1'b0;
    run_vec('{11'd100, 11'd200, 12'h0AA, 1'b0, 2'd0, 1'b0, 13'd0, 6'd0, 12'h0AA}, "clr s0");
    run_vec('{11'd300, 11'd300, 12'h0BB, 1'b0, 2'd0, 1'b0, 13'd0, 6'd0, 12'h0BB}, "clr s3");
    run_vec('{11'd600, 11'd600, 12'h0CC, 1'b0, 2'd0, 1'b0, 13'd0, 6'd0, 12'h0CC}, "clr s5");
    run_vec('{11'd700, 11'd700, 12'h0DD, 1'b0, 2'd0, 1'b0, 13'd0, 6'd0, 12'h0DD}, "clr s6");

    // Reset during cycle 4 of CLEAR.
    write_slot(3'd0, 11'd100, 11'd200, 2'd1, 4'd5);
    set_pix(11'd110, 11'd205, 12'hABC, 1'b0, 1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    set_pix(11'd5, 11'd1023, 12'hABC, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("pre-rst rom_addr", rom_addr, 330);
    chk("pre-rst rgb_out", rgb_out, 12'hABC);
    rst = 1'b1;
    #1;
    chk("midclr clear_done", clear_done, 0);
    chk("midclr rom_addr", rom_addr, 0);
    chk("midclr card_id", card_id, 0);
    chk("midclr rgb_out", rgb_out, 0);
    chk("midclr hcount_out", hcount_out, 0);
    tick();
    rst = 1'b0;
    last_addr = 13'd0;
    tick();
    chk("refill1 rgb_out", rgb_out, 0);
    tick();
    chk("refill2 rgb_out", rgb_out, 12'hABC);
    vblnk_in = 1'b1;
    #1;
    chk("post-rst wr_ready", slot_wr_ready, 1);
    seen_done = 0;
    for (int k = 0; k < 12; k++) begin
      if (clear_done) seen_done++;
      tick();
    end
    chk("post-rst no clear_done", seen_done, 0);
    run_vec('{11'd100, 11'd200, 12'h5A5, 1'b0, 2'd0, 1'b0, 13'd0, 6'd0, 12'h5A5}, "post-rst s0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
